// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: pipelined multi-lane signed MAC, last-delimited bursts.
// Define MYPROJECT_MAC_SAT_EN for saturating output conversion with ovf flags.
module myproject_mac_pipe #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int LANES      = 4,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int dout_WIDTH = 18
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_last,
   input  logic [LANES*din0_WIDTH-1:0]   din0,
   input  logic [LANES*din1_WIDTH-1:0]   din1,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*dout_WIDTH-1:0]   dout,
   output logic [LANES-1:0]              ovf
);
   localparam int PW = din0_WIDTH + din1_WIDTH;
   localparam int PD = NUM_STAGE - 1;

   if (NUM_STAGE < 2 || NUM_STAGE > 6 || ACC_WIDTH < PW || ID < 0) begin : g_bad_cfg
      $error("myproject_mac_pipe: illegal configuration");
   end

   logic                        ce;
   logic signed [PW-1:0]        prod_in [LANES];
   logic signed [PW-1:0]        prod_q  [PD][LANES];
   logic signed [PW-1:0]        prod_d  [PD][LANES];
   logic [PD-1:0]               vld_q, vld_d;
   logic [PD-1:0]               lst_q, lst_d;
   logic signed [ACC_WIDTH-1:0] acc_q   [LANES];
   logic signed [ACC_WIDTH-1:0] acc_d   [LANES];
   logic signed [ACC_WIDTH-1:0] acc_nx  [LANES];
   logic                        first_q, first_d;
   logic                        out_valid_q, out_valid_d;
   logic [LANES*dout_WIDTH-1:0] dout_q, dout_d;
   logic [LANES-1:0]            ovf_q, ovf_d;
   logic [dout_WIDTH-1:0]       conv_v  [LANES];
   logic [LANES-1:0]            conv_o;
   logic                        tail_v, tail_l;

   assign ce        = !out_valid_q || out_ready;
   assign in_ready  = ce;
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign ovf       = ovf_q;
   assign tail_v    = vld_q[PD-1];
   assign tail_l    = lst_q[PD-1];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [din0_WIDTH-1:0] a;
      logic signed [din1_WIDTH-1:0] b;
      assign a = din0[k*din0_WIDTH +: din0_WIDTH];
      assign b = din1[k*din1_WIDTH +: din1_WIDTH];
      // full-width product: -2^(w-1) * -2^(w-1) stays exact
      assign prod_in[k] = PW'(a) * PW'(b);
      assign acc_nx[k]  = (first_q ? ACC_WIDTH'(0) : acc_q[k])
                        + ACC_WIDTH'(prod_q[PD-1][k]);
`ifdef MYPROJECT_MAC_SAT_EN
      localparam logic signed [ACC_WIDTH-1:0] DMAX =
         ACC_WIDTH'((longint'(1) <<< (dout_WIDTH-1)) - 1);
      localparam logic signed [ACC_WIDTH-1:0] DMIN = ~DMAX;
      logic hi, lo;
      assign hi = acc_nx[k] > DMAX;
      assign lo = acc_nx[k] < DMIN;
      assign conv_v[k] = hi ? DMAX[dout_WIDTH-1:0] :
                         lo ? DMIN[dout_WIDTH-1:0] :
                              acc_nx[k][dout_WIDTH-1:0];
      assign conv_o[k] = hi | lo;
`else
      assign conv_v[k] = acc_nx[k][dout_WIDTH-1:0];
      assign conv_o[k] = 1'b0;
`endif
   end

   always_comb begin
      prod_d = prod_q;
      vld_d  = vld_q;
      lst_d  = lst_q;
      if (ce) begin
         prod_d[0] = prod_in;
         vld_d[0]  = in_valid;
         lst_d[0]  = in_last;
         for (int s = 1; s < PD; s++) begin
            prod_d[s] = prod_q[s-1];
            vld_d[s]  = vld_q[s-1];
            lst_d[s]  = lst_q[s-1];
         end
      end
   end

   always_comb begin
      acc_d       = acc_q;
      first_d     = first_q;
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      ovf_d       = ovf_q;
      if (ce) begin
         out_valid_d = tail_v && tail_l;
         if (tail_v) begin
            acc_d   = acc_nx;
            first_d = tail_l;
         end
         if (tail_v && tail_l) begin
            for (int k = 0; k < LANES; k++)
               dout_d[k*dout_WIDTH +: dout_WIDTH] = conv_v[k];
            ovf_d = conv_o;
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int s = 0; s < PD; s++)
            for (int k = 0; k < LANES; k++)
               prod_q[s][k] <= '0;
         for (int k = 0; k < LANES; k++)
            acc_q[k] <= '0;
         vld_q       <= '0;
         lst_q       <= '0;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         ovf_q       <= '0;
      end else begin
         prod_q      <= prod_d;
         vld_q       <= vld_d;
         lst_q       <= lst_d;
         acc_q       <= acc_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         ovf_q       <= ovf_d;
      end
   end
endmodule

// File: tb/tb_myproject_mac_pipe.sv
// tb_myproject_mac_pipe: random + directed check of myproject_mac_pipe
// against a burst-sum reference model.
module tb_myproject_mac_pipe;
   localparam int NS = 3;
   localparam int L  = 4;
   localparam int W0 = 16;
   localparam int W1 = 8;
   localparam int AW = 24;
   localparam int DW = 18;

   logic            ap_clk = 1'b0;
   logic            ap_rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            in_last = 1'b0;
   logic [L*W0-1:0] din0 = '0;
   logic [L*W1-1:0] din1 = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [L*DW-1:0] dout;
   logic [L-1:0]    ovf;

   int tests = 0;
   int fails = 0;

   always #5 ap_clk = ~ap_clk;

   myproject_mac_pipe #(
      .ID(1), .NUM_STAGE(NS), .LANES(L), .din0_WIDTH(W0),
      .din1_WIDTH(W1), .ACC_WIDTH(AW), .dout_WIDTH(DW)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .din0(din0), .din1(din1),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .ovf(ovf)
   );

   function automatic void chk(string nm, longint act, longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endfunction

   function automatic longint wrap_s(longint v, int w);
      longint m;
      m = v & ((longint'(1) << w) - 1);
      if (m >= (longint'(1) << (w-1))) m -= (longint'(1) << w);
      return m;
   endfunction

   function automatic longint conv(longint s, output logic o);
      longint a;
      a = wrap_s(s, AW);
      o = 1'b0;
`ifdef MYPROJECT_MAC_SAT_EN
      begin
         longint mx;
         mx = (longint'(1) << (DW-1)) - 1;
         if (a > mx) begin o = 1'b1; return mx; end
         if (a < -mx-1) begin o = 1'b1; return -mx-1; end
         return a;
      end
`else
      return wrap_s(a, DW);
`endif
   endfunction

   function automatic longint lane_out(int k);
      return wrap_s(longint'(dout[k*DW +: DW]), DW);
   endfunction

   function automatic logic [L*W0-1:0] put0(logic [L*W0-1:0] v, int k, longint x);
      v[k*W0 +: W0] = W0'(x);
      return v;
   endfunction

   function automatic logic [L*W1-1:0] put1(logic [L*W1-1:0] v, int k, longint x);
      v[k*W1 +: W1] = W1'(x);
      return v;
   endfunction

   // reference model: per-lane running sum of accepted beats, one result per last
   longint          sum [L];
   logic [L*DW-1:0] qd [$];
   logic [L-1:0]    qo [$];
   logic            stall_p = 1'b0;
   logic [L*DW-1:0] dout_p;
   logic [L-1:0]    ovf_p;

   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         chk("rst_out_valid", longint'(out_valid), 0);
         chk("rst_dout_nonzero", longint'(dout != '0), 0);
         chk("rst_ovf", longint'(ovf), 0);
         chk("rst_in_ready", longint'(in_ready), 1);
         for (int k = 0; k < L; k++) sum[k] = 0;
         qd.delete();
         qo.delete();
         stall_p = 1'b0;
      end else begin
         chk("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
         if (stall_p) begin
            chk("hold_out_valid", longint'(out_valid), 1);
            chk("hold_dout_changed", longint'(dout != dout_p), 0);
            chk("hold_ovf", longint'(ovf), longint'(ovf_p));
         end
         if (out_valid && out_ready) begin
            if (qd.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               logic [L*DW-1:0] ed;
               logic [L-1:0]    eo;
               ed = qd.pop_front();
               eo = qo.pop_front();
               for (int k = 0; k < L; k++)
                  chk($sformatf("dout_lane%0d", k), lane_out(k),
                      wrap_s(longint'(ed[k*DW +: DW]), DW));
               chk("ovf", longint'(ovf), longint'(eo));
            end
         end
         if (in_valid && in_ready) begin
            for (int k = 0; k < L; k++)
               sum[k] += longint'($signed(din0[k*W0 +: W0]))
                       * longint'($signed(din1[k*W1 +: W1]));
            if (in_last) begin
               logic [L*DW-1:0] ev;
               logic [L-1:0]    eo;
               for (int k = 0; k < L; k++) begin
                  logic o;
                  ev[k*DW +: DW] = DW'(conv(sum[k], o));
                  eo[k] = o;
                  sum[k] = 0;
               end
               qd.push_back(ev);
               qo.push_back(eo);
            end
         end
         stall_p = out_valid && !out_ready;
         dout_p  = dout;
         ovf_p   = ovf;
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic beat(logic l, logic [L*W0-1:0] a, logic [L*W1-1:0] b);
      in_valid = 1'b1;
      in_last  = l;
      din0     = a;
      din1     = b;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      if (!out_valid) chk("wait_out_timeout", 0, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int              lat;
      int              n;
      int              runs;
      logic            pv;
      longint          v;
      logic            o;
      longint          f0;
      longint          f3;
      logic [L*W0-1:0] a;
      logic [L*W1-1:0] b;

      ap_rst_n = 1'b0;
      repeat (2) tick();
      ap_rst_n = 1'b1;
      tick();
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_in_ready", longint'(in_ready), 1);
      chk("reset_dout_nonzero", longint'(dout != '0), 0);

      // single beat 100 * -3
      a = put0('0, 0, 100);
      b = put1('0, 0, -3);
      beat(1'b1, a, b);
      chk("t1_early_valid", longint'(out_valid), 0);
      wait_out(lat);
      chk("t1_latency", longint'(lat), NS - 1);
      chk("t1_dout0", lane_out(0), -300);
      chk("t1_ovf", longint'(ovf), 0);
      tick();

      // extreme operands
      a = put0('0, 0, -32768);
      b = put1('0, 0, -128);
      beat(1'b1, a, b);
      wait_out(lat);
`ifdef MYPROJECT_MAC_SAT_EN
      chk("t2_dout0", lane_out(0), 131071);
      chk("t2_ovf", longint'(ovf), 1);
`else
      chk("t2_dout0", lane_out(0), 0);
      chk("t2_ovf", longint'(ovf), 0);
`endif
      tick();

      // 4-beat burst on lane1
      a = put0('0, 1, 1000);
      b = put1('0, 1, 100);
      n = 0;
      v = 0;
      o = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i < 4);
         in_last  = (i == 3);
         din0 = a;
         din1 = b;
         tick();
         if (out_valid) begin
            n++;
            v = lane_out(1);
            o = ovf[1];
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("t3_result_count", longint'(n), 1);
`ifdef MYPROJECT_MAC_SAT_EN
      chk("t3_dout1", v, 131071);
      chk("t3_ovf1", longint'(o), 1);
`else
      chk("t3_dout1", v, -124288);
      chk("t3_ovf1", longint'(o), 0);
`endif

      // 8 back-to-back single-beat results
      n = 0;
      runs = 0;
      pv = 1'b0;
      f0 = 0;
      f3 = 0;
      for (int i = 0; i < 14; i++) begin
         if (i < 8) begin
            for (int k = 0; k < L; k++) begin
               a = put0(a, k, i*100 + k*7 + 1);
               b = put1(b, k, k - 2 + i);
            end
         end
         in_valid = (i < 8);
         in_last  = (i < 8);
         din0 = a;
         din1 = b;
         tick();
         if (out_valid) begin
            n++;
            if (n == 1) begin
               f0 = lane_out(0);
               f3 = lane_out(3);
            end
            if (!pv) runs++;
         end
         pv = out_valid;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("t4_count", longint'(n), 8);
      chk("t4_runs", longint'(runs), 1);
      chk("t4_first_lane0", f0, -2);
      chk("t4_first_lane3", f3, 22);

      // backpressure for 3 cycles
      a = put0('0, 2, 300);
      b = put1('0, 2, -7);
      beat(1'b1, a, b);
      a = put0('0, 2, -50);
      b = put1('0, 2, 9);
      beat(1'b1, a, b);
      out_ready = 1'b0;
      wait_out(lat);
      in_valid = 1'b1;
      in_last  = 1'b1;
      din0 = put0('0, 2, 2);
      din1 = put1('0, 2, 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_stall_valid", longint'(out_valid), 1);
         chk("t5_stall_in_ready", longint'(in_ready), 0);
         chk("t5_stall_dout2", lane_out(2), -2100);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("t5_next_valid", longint'(out_valid), 1);
      chk("t5_next_dout2", lane_out(2), -450);
      tick();
      wait_out(lat);
      chk("t5_third_dout2", lane_out(2), 4);
      tick();

      // reset in the middle of a burst
      a = put0('0, 0, 7);
      b = put1('0, 0, 7);
      beat(1'b0, a, b);
      beat(1'b0, a, b);
      ap_rst_n = 1'b0;
      tick();
      chk("t6_rst_valid", longint'(out_valid), 0);
      chk("t6_rst_dout_nonzero", longint'(dout != '0), 0);
      chk("t6_rst_ovf", longint'(ovf), 0);
      tick();
      ap_rst_n = 1'b1;
      tick();
      a = put0('0, 0, 5);
      b = put1('0, 0, 5);
      beat(1'b1, a, b);
      wait_out(lat);
      chk("t6_dout0", lane_out(0), 25);
      tick();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(9) < 7);
         in_last   = ($urandom_range(3) == 0);
         out_ready = ($urandom_range(9) < 7);
         din0 = {$urandom(), $urandom()};
         din1 = $urandom();
         if ($urandom_range(7) == 0) begin
            for (int k = 0; k < L; k++) begin
               din0 = put0(din0, k, -32768);
               din1 = put1(din1, k, -128);
            end
         end
         if (i == 700) ap_rst_n = 1'b0;
         if (i == 702) ap_rst_n = 1'b1;
         tick();
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();
      chk("drain_queue_empty", longint'(qd.size()), 0);
      chk("drain_out_valid", longint'(out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/myproject_mac_pipe.md
# myproject_mac_pipe

Parametrised, pipelined, multi-lane signed multiply-accumulate engine. It succeeds the single-cycle combinational signed multipliers used in the generated datapath. It adds a configurable pipeline depth, LANES parallel channels, per-lane accumulation over a last-delimited burst, valid/ready backpressure, and a defined output width conversion. It sits between the weight/activation feed and the layer bias/activation stage of dense layers.

## Interface
- ID, 1: instance tag, no functional effect
- NUM_STAGE, 2: pipeline depth in cycles, legal range 2..6
- LANES, 4: number of independent multiply-accumulate channels
- din0_WIDTH, 16: signed width of each lane's first operand
- din1_WIDTH, 8: signed width of each lane's second operand
- ACC_WIDTH, 24: signed accumulator width; must be ≥ din0_WIDTH+din1_WIDTH
- dout_WIDTH, 18: signed width of each lane's result
- ap_clk  in  1  sole clock; all state updates on the rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_last  in  1  final beat of an accumulation burst
- din0  in  LANES*din0_WIDTH  lane k occupies bits [k*din0_WIDTH +: din0_WIDTH]
- din1  in  LANES*din1_WIDTH  packed the same way
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- dout  out  LANES*dout_WIDTH  packed per-lane results
- ovf  out  LANES  per-lane overflow flag, qualified by out_valid

## Operation
- Global enable: ce = !out_valid || out_ready. in_ready = ce. When ce=0, every stage register, the accumulators, and the first-beat flag hold.
- Stage 1: prod[k] = $signed(din0[k]) * $signed(din1[k]), full width din0_WIDTH+din1_WIDTH. It is registered with the beat's valid and last.
- Stages 2..NUM_STAGE-1: pure delay of the product, valid and last.
- Stage NUM_STAGE (accumulate/output):
  - On a valid beat: acc[k] <= (first ? 0 : acc[k]) + sign-extended prod[k], wrapping modulo 2^ACC_WIDTH.
  - first is set after reset and after any beat with last=1. It is cleared by any valid beat with last=0.
- On a beat with last=1: out_valid <= 1, dout[k] <= conv(acc_next[k]), ovf[k] <= conversion overflow. Beats with last=0 produce no output.
- conv: reduction from ACC_WIDTH to dout_WIDTH; see Configuration.
- in_last=1 on every beat gives a plain pipelined multiply with throughput 1/cycle.
- out_valid clears on out_valid && out_ready unless a new last beat lands in the same cycle.
- Bubbles (in_valid=0) propagate as invalid stage slots and do not disturb acc.

## Timing
- Reset values: out_valid=0, dout=0, ovf=0, in_ready=1 (follows from out_valid=0), all stage valids 0, acc=0, first=1.
- Latency: a last beat accepted at edge t gives out_valid=1 after edge t+NUM_STAGE-1, i.e. visible in cycle t+NUM_STAGE-1, with NUM_STAGE register stages total.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure:
  - When out_valid=1 and out_ready=0, dout and ovf are stable and in_ready=0.
  - The pipeline is not compressed; bubbles remain.
- Simultaneous out_ready and a new last beat: the old result is consumed and the new result loaded in the same edge, with no gap.
- Reset mid-burst: the partial accumulation is discarded and the next accepted beat starts a new burst.
- Operands of extreme magnitude (-2^(w-1) × -2^(w-1)) are exact in the product; no internal saturation occurs before conv.

## Configuration
- MYPROJECT_MAC_SAT_EN defined:
  - conv clamps to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - ovf[k]=1 when clamping occurred for lane k.
- MYPROJECT_MAC_SAT_EN undefined:
  - conv takes the low dout_WIDTH bits of the accumulator, two's-complement wrap, matching the legacy multiplier truncation.
  - ovf is tied to 0.

## Test plan
- Reset, then single beat with lane0 din0=100, din1=-3, last=1 -> out_valid after NUM_STAGE-1 cycles, dout lane0 = -300, ovf=0.
- Lane0 din0=-32768, din1=-128, last=1 -> product 4194304. With SAT_EN: dout=131071, ovf[0]=1. Without: dout=0, ovf=0.
- Burst of 4 beats, lane1 din0=1000, din1=100, last on beat 4 -> one result only. With SAT_EN: 131071 and ovf[1]=1. Without: -124288.
- Streaming 8 beats with last=1 and out_ready=1 -> 8 consecutive results in order at 1/cycle, with lanes independent (distinct per-lane values checked).
- Hold out_ready=0 for 3 cycles while out_valid=1 -> dout, ovf and out_valid stable, in_ready=0, no beat lost or duplicated after release.
- Assert ap_rst_n low after 2 beats of a last=0 burst, then send 1 beat (5×5, last=1) -> dout lane=25; all outputs read 0 during reset.
